systolic_matrix_mult: RTL and testbench

//  Fixed-point matrix multiplier C[MxN] = A[MxK] * B[KxN] on an MxN output-stationary systolic PE array.
//  A and B are loaded element-by-element with explicit indices, then computed.
//  C is streamed out row-major with indices.

---
 rtl/systolic_matrix_mult.sv | 230 +++++++++++++++++++++++
 tb/tb_systolic_matrix_mult.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_matrix_mult.sv
// systolic_matrix_mult: fixed-point GEMM engine, C[MxN] = A[MxK] * B[KxN].
// A and B are written element-by-element into local buffers. Once every element
// has been written, the operands are streamed through an MxN output-stationary
// systolic PE array. C is then read out in row-major order.
// Optional build macro: SYSTOLIC_SATURATE_EN. When it is defined, results clamp
// to the signed DATA_WIDTH range. Without it, the upper bits wrap.
module systolic_matrix_mult #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int M          = 4,
    parameter int N          = 2,
    parameter int K          = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] a_data,
    input  logic        [$clog2(M)-1:0]  a_row,
    input  logic        [$clog2(K)-1:0]  a_col,
    input  logic                         a_valid,
    input  logic signed [DATA_WIDTH-1:0] b_data,
    input  logic        [$clog2(K)-1:0]  b_row,
    input  logic        [$clog2(N)-1:0]  b_col,
    input  logic                         b_valid,
    output logic signed [DATA_WIDTH-1:0] c_data,
    output logic        [$clog2(M)-1:0]  c_row,
    output logic        [$clog2(N)-1:0]  c_col,
    output logic                         c_valid,
    output logic                         done
);

    localparam int RW    = $clog2(M);
    localparam int NW    = $clog2(N);
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int AW    = PW + $clog2(K);
    localparam int EXT   = AW - PW;
    localparam int STEPS = K + M + N - 2;
    localparam int TW    = $clog2(STEPS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_OUTPUT,
        ST_DONE
    } state_t;

    state_t state;

    logic signed [DATA_WIDTH-1:0] a_buf [M][K];
    logic signed [DATA_WIDTH-1:0] b_buf [K][N];
    logic [M-1:0][K-1:0]          a_flag;
    logic [K-1:0][N-1:0]          b_flag;

    logic [TW-1:0] comp_cnt;
    logic [RW-1:0] out_row;
    logic [NW-1:0] out_col;

    // Operand skew registers between neighbouring PEs, plus the per-PE accumulators.
    logic signed [DATA_WIDTH-1:0] a_pipe_p0 [M][N-1];
    logic signed [DATA_WIDTH-1:0] b_pipe_p0 [M-1][N];
    logic signed [AW-1:0]         acc_p1    [M][N];

    logic signed [DATA_WIDTH-1:0] a_edge [M];
    logic signed [DATA_WIDTH-1:0] b_edge [N];
    logic signed [DATA_WIDTH-1:0] a_in   [M][N];
    logic signed [DATA_WIDTH-1:0] b_in   [M][N];
    logic signed [PW-1:0]         prod   [M][N];

    logic vld_p0;
    logic a_wr;
    logic b_wr;
    logic load_full;

    // Drop the fractional bits of an accumulator and fit the value to DATA_WIDTH (wrap or clamp).
    function automatic logic signed [DATA_WIDTH-1:0] fmt_result(input logic signed [AW-1:0] acc);
`ifdef SYSTOLIC_SATURATE_EN
        logic signed [AW-1:0] sh;
        logic signed [AW-1:0] sat_max;
        logic signed [AW-1:0] sat_min;
        sat_max = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
        sat_min = {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
        sh      = acc >>> FRAC_WIDTH;
        if (sh > sat_max)
            return sat_max[DATA_WIDTH-1:0];
        else if (sh < sat_min)
            return sat_min[DATA_WIDTH-1:0];
        else
            return sh[DATA_WIDTH-1:0];
`else
        return acc[DATA_WIDTH+FRAC_WIDTH-1:FRAC_WIDTH];
`endif
    endfunction

    assign vld_p0    = (state == ST_COMPUTE);
    assign a_wr      = (state == ST_LOAD) && a_valid && (int'(a_row) < M) && (int'(a_col) < K);
    assign b_wr      = (state == ST_LOAD) && b_valid && (int'(b_row) < K) && (int'(b_col) < N);
    assign load_full = (&a_flag) && (&b_flag);

    // Feed the skewed array edges and wire each PE to its left and upper neighbour.
    always_comb begin
        for (int i = 0; i < M; i++) begin
            a_edge[i] = '0;
            for (int k = 0; k < K; k++)
                if (int'(comp_cnt) == i + k) a_edge[i] = a_buf[i][k];
        end
        for (int j = 0; j < N; j++) begin
            b_edge[j] = '0;
            for (int k = 0; k < K; k++)
                if (int'(comp_cnt) == j + k) b_edge[j] = b_buf[k][j];
        end
        for (int i = 0; i < M; i++) begin
            a_in[i][0] = a_edge[i];
            for (int j = 1; j < N; j++) a_in[i][j] = a_pipe_p0[i][j-1];
        end
        for (int j = 0; j < N; j++) begin
            b_in[0][j] = b_edge[j];
            for (int i = 1; i < M; i++) b_in[i][j] = b_pipe_p0[i-1][j];
        end
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                prod[i][j] = PW'(a_in[i][j]) * PW'(b_in[i][j]);
    end

    // Operand buffers, written-flags and the PE array (multiply-accumulate plus operand forwarding).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_flag <= '0;
            b_flag <= '0;
            for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) a_buf[i][k] <= '0;
            for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) b_buf[k][j] <= '0;
            for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) acc_p1[i][j] <= '0;
            for (int i = 0; i < M; i++) for (int j = 0; j < N-1; j++) a_pipe_p0[i][j] <= '0;
            for (int i = 0; i < M-1; i++) for (int j = 0; j < N; j++) b_pipe_p0[i][j] <= '0;
        end else if (start) begin
            a_flag <= '0;
            b_flag <= '0;
            for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) a_buf[i][k] <= '0;
            for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) b_buf[k][j] <= '0;
            for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) acc_p1[i][j] <= '0;
            for (int i = 0; i < M; i++) for (int j = 0; j < N-1; j++) a_pipe_p0[i][j] <= '0;
            for (int i = 0; i < M-1; i++) for (int j = 0; j < N; j++) b_pipe_p0[i][j] <= '0;
        end else begin
            if (a_wr) begin
                a_buf[a_row][a_col]  <= a_data;
                a_flag[a_row][a_col] <= 1'b1;
            end
            if (b_wr) begin
                b_buf[b_row][b_col]  <= b_data;
                b_flag[b_row][b_col] <= 1'b1;
            end
            // Stage boundary: skewed operands -> accumulators / neighbour registers.
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (vld_p0)
                        acc_p1[i][j] <= acc_p1[i][j] + {{EXT{prod[i][j][PW-1]}}, prod[i][j]};
                end
            end
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N-1; j++)
                    a_pipe_p0[i][j] <= vld_p0 ? a_in[i][j] : '0;
            for (int i = 0; i < M-1; i++)
                for (int j = 0; j < N; j++)
                    b_pipe_p0[i][j] <= vld_p0 ? b_in[i][j] : '0;
        end
    end

    // Job sequencing and registered result streaming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            comp_cnt <= '0;
            out_row  <= '0;
            out_col  <= '0;
            c_valid  <= 1'b0;
            c_data   <= '0;
            c_row    <= '0;
            c_col    <= '0;
            done     <= 1'b0;
        end else if (start) begin
            state    <= ST_LOAD;
            comp_cnt <= '0;
            c_valid  <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    c_valid <= 1'b0;
                    done    <= 1'b0;
                end
                ST_LOAD: begin
                    if (load_full) begin
                        state    <= ST_COMPUTE;
                        comp_cnt <= '0;
                    end
                end
                ST_COMPUTE: begin
                    if (comp_cnt == TW'(STEPS - 1)) begin
                        state   <= ST_OUTPUT;
                        out_row <= '0;
                        out_col <= '0;
                    end else begin
                        comp_cnt <= comp_cnt + 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    c_valid <= 1'b1;
                    c_data  <= fmt_result(acc_p1[out_row][out_col]);
                    c_row   <= out_row;
                    c_col   <= out_col;
                    if (out_col == NW'(N - 1)) begin
                        out_col <= '0;
                        if (out_row == RW'(M - 1))
                            state <= ST_DONE;
                        else
                            out_row <= out_row + 1'b1;
                    end else begin
                        out_col <= out_col + 1'b1;
                    end
                end
                ST_DONE: begin
                    c_valid <= 1'b0;
                    done    <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_matrix_mult.sv
// Directed bench for systolic_matrix_mult (4x3 * 3x2, Q8.8) with a queue scoreboard.
module tb_systolic_matrix_mult;

    localparam int DW = 16;
    localparam int FW = 8;
    localparam int M  = 4;
    localparam int N  = 2;
    localparam int K  = 3;
    localparam int RW = $clog2(M);
    localparam int NW = $clog2(N);
    localparam int KW = $clog2(K);

    typedef struct {
        logic [RW-1:0] row;
        logic [NW-1:0] col;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] a_data = '0;
    logic [RW-1:0] a_row = '0;
    logic [KW-1:0] a_col = '0;
    logic          a_valid = 1'b0;
    logic [DW-1:0] b_data = '0;
    logic [KW-1:0] b_row = '0;
    logic [NW-1:0] b_col = '0;
    logic          b_valid = 1'b0;
    logic [DW-1:0] c_data;
    logic [RW-1:0] c_row;
    logic [NW-1:0] c_col;
    logic          c_valid;
    logic          done;

    int checks = 0;
    int errors = 0;
    beat_t sb[$];
    logic signed [DW-1:0] am [M][K];
    logic signed [DW-1:0] bm [K][N];

    systolic_matrix_mult #(.DATA_WIDTH(DW), .FRAC_WIDTH(FW), .M(M), .N(N), .K(K)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_data(a_data), .a_row(a_row), .a_col(a_col), .a_valid(a_valid),
        .b_data(b_data), .b_row(b_row), .b_col(b_col), .b_valid(b_valid),
        .c_data(c_data), .c_row(c_row), .c_col(c_col), .c_valid(c_valid), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic write_a(input int r, input int c, input logic [DW-1:0] v);
        @(negedge clk);
        a_valid = 1'b1; a_row = RW'(r); a_col = KW'(c); a_data = v;
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic write_b(input int r, input int c, input logic [DW-1:0] v);
        @(negedge clk);
        b_valid = 1'b1; b_row = KW'(r); b_col = NW'(c); b_data = v;
        @(negedge clk);
        b_valid = 1'b0;
    endtask

    // A and B written concurrently; optionally leave out the last B element (B[K-1][N-1]).
    task automatic load_mats(input bit skip_last_b);
        for (int t = 0; t < M*K; t++) begin
            @(negedge clk);
            a_valid = 1'b1; a_row = RW'(t / K); a_col = KW'(t % K); a_data = am[t/K][t%K];
            if (t < K*N && !(skip_last_b && t == K*N-1)) begin
                b_valid = 1'b1; b_row = KW'(t / N); b_col = NW'(t % N); b_data = bm[t/N][t%N];
            end else begin
                b_valid = 1'b0;
            end
        end
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    // Reference product from the bench's own copy of A and B.
    task automatic push_expected();
        longint s;
        longint sh;
        beat_t e;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < K; k++) s += longint'(am[i][k]) * longint'(bm[k][j]);
                sh = s >>> FW;
                e.row = RW'(i);
                e.col = NW'(j);
`ifdef SYSTOLIC_SATURATE_EN
                if (sh > 32767) e.data = 16'h7FFF;
                else if (sh < -32768) e.data = 16'h8000;
                else e.data = sh[DW-1:0];
`else
                e.data = sh[DW-1:0];
`endif
                sb.push_back(e);
            end
        end
    endtask

    task automatic collect(input string tag, input int budget);
        int cyc;
        beat_t e;
        cyc = 0;
        while (sb.size() > 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (c_valid) begin
                e = sb.pop_front();
                check({tag, "_data"}, 32'(c_data), 32'(e.data));
                check({tag, "_row"}, 32'(c_row), 32'(e.row));
                check({tag, "_col"}, 32'(c_col), 32'(e.col));
            end
        end
        check({tag, "_beats_left"}, 32'(sb.size()), 32'd0);
        sb.delete();
        @(negedge clk);
        check({tag, "_done_rise"}, 32'(done), 32'd1);
        check({tag, "_valid_after"}, 32'(c_valid), 32'd0);
        repeat (3) @(negedge clk);
        check({tag, "_done_hold"}, 32'(done), 32'd1);
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        int beats;
        int dones;
        beats = 0;
        dones = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (c_valid) beats++;
            if (done) dones++;
        end
        check({tag, "_no_valid"}, 32'(beats), 32'd0);
        check({tag, "_no_done"}, 32'(dones), 32'd0);
    endtask

    task automatic set_basic();
        am = '{'{16'sh0100, 16'sh0200, 16'sh0000},
               '{16'sh0300, 16'sh0400, 16'sh0000},
               '{16'sh0500, 16'sh0600, 16'sh0000},
               '{16'sh0100, 16'sh0000, 16'sh0100}};
        bm = '{'{16'sh0100, 16'sh0000},
               '{16'sh0000, 16'sh0100},
               '{16'sh0200, 16'sh0100}};
    endtask

    task automatic set_all(input logic signed [DW-1:0] av, input logic signed [DW-1:0] bv);
        for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) am[i][k] = av;
        for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) bm[k][j] = bv;
    endtask

    task automatic set_random();
        for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) am[i][k] = DW'($urandom);
        for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) bm[k][j] = DW'($urandom);
    endtask

    initial begin
        int beats;
        beat_t e;

        // Reset and idle behaviour
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(c_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_data", 32'(c_data), 32'd0);
        check("rst_row", 32'(c_row), 32'd0);
        check("rst_col", 32'(c_col), 32'd0);
        rst_n = 1'b1;
        set_basic();
        load_mats(1'b0);
        watch_quiet("idle", 30);

        // Basic Q8.8 job with concurrent A/B load
        set_basic();
        pulse_start();
        load_mats(1'b0);
        push_expected();
        collect("basic", 100);

        // Signed fractions; stray writes during compute must be ignored
        set_all(16'shFE80, 16'sh0080);
        pulse_start();
        load_mats(1'b0);
        @(negedge clk);
        a_valid = 1'b1; a_row = '0; a_col = '0; a_data = 16'h7FFF;
        b_valid = 1'b1; b_row = '0; b_col = '0; b_data = 16'h7FFF;
        repeat (4) @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        push_expected();
        collect("signed", 100);

        // Incomplete load stalls until the missing B element arrives
        set_basic();
        pulse_start();
        load_mats(1'b1);
        watch_quiet("incomplete", 40);
        write_b(K-1, N-1, bm[K-1][N-1]);
        push_expected();
        collect("completed", 100);

        // Out-of-range writes ignored, overwrite keeps the latest value
        set_basic();
        pulse_start();
        write_a(0, 3, 16'h7F00);
        write_b(3, 0, 16'h7F00);
        load_mats(1'b1);
        am[0][0] = 16'sh0200;
        write_a(0, 0, 16'h0200);
        push_expected();
        write_b(K-1, N-1, bm[K-1][N-1]);
        collect("overwrite", 100);

        // Restart during OUTPUT
        set_basic();
        pulse_start();
        load_mats(1'b0);
        push_expected();
        beats = 0;
        for (int c = 0; c < 100 && beats < 3; c++) begin
            @(negedge clk);
            if (c_valid) begin
                e = sb.pop_front();
                check("part_data", 32'(c_data), 32'(e.data));
                beats++;
            end
        end
        check("part_beats", 32'(beats), 32'd3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_valid", 32'(c_valid), 32'd0);
        check("restart_done", 32'(done), 32'd0);
        sb.delete();
        set_random();
        load_mats(1'b0);
        push_expected();
        collect("restart_job", 100);

        // Overflow: wraps by default, clamps with saturation enabled
        set_all(16'sh7F00, 16'sh7F00);
        pulse_start();
        load_mats(1'b0);
        push_expected();
        collect("overflow", 100);

        // Reset mid-job discards everything
        set_basic();
        pulse_start();
        load_mats(1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(c_valid), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_data", 32'(c_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_quiet("after_rst", 30);

        // Random operands
        set_random();
        pulse_start();
        load_mats(1'b0);
        push_expected();
        collect("random", 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
